// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the PCPU hazard/interlock controller.
// Build option: HAZARD_PERF_CNT_EN adds load-use / MUL-DIV stall counters
// to hazard_ctrl.
package pcpu_hazard_pkg;

   // Default GPR address width (32 registers).
   localparam int REG_AW_DEF = 5;

   // Operand source select driven to the EX-stage operand muxes.
   typedef enum logic [1:0] {
      FWD_RF     = 2'd0,
      FWD_EXALU  = 2'd1,
      FWD_MEMALU = 2'd2,
      FWD_MEMLD  = 2'd3
   } fwd_sel_t;

   // MUL/DIV sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: decoder/EX/MEM information in,
// interlock, flush and forwarding controls out.
interface hazard_ctrl_if #(
   parameter int REG_AW = pcpu_hazard_pkg::REG_AW_DEF
) ();
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_need_rs;
   logic              id_need_rt;
   logic              id_branch;
   logic              id_md_start;
   logic              id_hilo_rd;
   logic              ex_wreg;
   logic              ex_m2reg;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_wreg;
   logic              mem_m2reg;
   logic [REG_AW-1:0] mem_rd;

   logic              wpcir;
   logic              bubble;
   logic              flush_ifid;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              md_busy;
   logic              md_done;

   // Pipeline side: supplies stage information, consumes controls.
   modport master (
      output id_rs, id_rt, id_need_rs, id_need_rt, id_branch, id_md_start,
             id_hilo_rd, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd,
      input  wpcir, bubble, flush_ifid, fwd_a, fwd_b, md_busy, md_done
   );

   // Controller side.
   modport slave (
      input  id_rs, id_rt, id_need_rs, id_need_rt, id_branch, id_md_start,
             id_hilo_rd, ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd,
      output wpcir, bubble, flush_ifid, fwd_a, fwd_b, md_busy, md_done
   );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// MUL/DIV sequencer: IDLE -> BUSY (MD_LAT-1 cycles) -> DONE (1 cycle).
// The md_done pulse lands MD_LAT cycles after the accepting edge.
module md_seq
   import pcpu_hazard_pkg::*;
#(
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   output logic active
);

   // Counter must hold MD_LAT-1 without wrapping; latency below 2 has no BUSY phase.
   if (MD_LAT < 2 || MD_LAT > (2**CNT_W) - 1) begin : g_bad_cfg
      $error("md_seq: MD_LAT must be in 2..2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LAT - 1);

   md_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   // State and counter registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples the pre-edge values of its inputs.
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next state: BUSY counts down and hands off to DONE as the count reaches 0.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = BUSY;
               cnt_n   = LOAD_VAL;
            end
         end
         BUSY: begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt_n == '0) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy   = (state == BUSY);
   assign done   = (state == DONE);
   assign active = (state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and interlock controller for the 5-stage PCPU:
// operand forwarding, load-use stall, MUL/DIV interlock and branch flush.
// Build option: HAZARD_PERF_CNT_EN adds saturating stall counters
// perf_lu_cnt / perf_md_cnt.
module hazard_ctrl
   import pcpu_hazard_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]  perf_lu_cnt,
   output logic [31:0]  perf_md_cnt
`endif
);

   logic [REG_AW-1:0] rs, rt, ex_rd, mem_rd;
   fwd_sel_t          fwd_a, fwd_b;
   logic              lu, md_hz, stall;
   logic              md_active, md_start;

   assign rs     = hif.id_rs;
   assign rt     = hif.id_rt;
   assign ex_rd  = hif.ex_rd;
   assign mem_rd = hif.mem_rd;

   // Per-operand source select; EX beats MEM, r0 is never forwarded, and an
   // EX load cannot forward (its data does not exist yet).
   always_comb begin
      fwd_a = FWD_RF;
      if (hif.id_need_rs && hif.ex_wreg && !hif.ex_m2reg &&
          ex_rd == rs && ex_rd != '0)
         fwd_a = FWD_EXALU;
      else if (hif.id_need_rs && hif.mem_wreg && mem_rd == rs && mem_rd != '0)
         fwd_a = hif.mem_m2reg ? FWD_MEMLD : FWD_MEMALU;

      fwd_b = FWD_RF;
      if (hif.id_need_rt && hif.ex_wreg && !hif.ex_m2reg &&
          ex_rd == rt && ex_rd != '0)
         fwd_b = FWD_EXALU;
      else if (hif.id_need_rt && hif.mem_wreg && mem_rd == rt && mem_rd != '0)
         fwd_b = hif.mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
   end

   // Stall sources: load in EX feeding ID, or MUL/DIV/HI-LO access while the
   // sequencer is not IDLE (DONE included, so mfhi never sees stale HI/LO).
   always_comb begin
      lu = hif.ex_wreg && hif.ex_m2reg && (ex_rd != '0) &&
           ((hif.id_need_rs && ex_rd == rs) || (hif.id_need_rt && ex_rd == rt));
      md_hz = md_active && (hif.id_md_start || hif.id_hilo_rd);
      stall = lu || md_hz;
   end

   // A stalled mult/div is not accepted; it starts on its retry cycle.
   assign md_start = hif.id_md_start && !stall;

   md_seq #(
      .MD_LAT (MD_LAT),
      .CNT_W  (CNT_W)
   ) u_md_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .busy   (hif.md_busy),
      .done   (hif.md_done),
      .active (md_active)
   );

   assign hif.wpcir      = !stall;
   assign hif.bubble     = stall;
   assign hif.flush_ifid = hif.id_branch && !stall;
   assign hif.fwd_a      = fwd_a;
   assign hif.fwd_b      = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating stall-cycle counters; a cycle with both causes counts as load-use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lu_cnt <= '0;
         perf_md_cnt <= '0;
      end else if (lu) begin
         if (perf_lu_cnt != 32'hFFFF_FFFF) perf_lu_cnt <= perf_lu_cnt + 32'd1;
      end else if (md_hz) begin
         if (perf_md_cnt != 32'hFFFF_FFFF) perf_md_cnt <= perf_md_cnt + 32'd1;
      end
   end
`endif

endmodule
